// File: rtl/iq_pkg.sv
// Shared types and sizing for the CIQ allocation stage.
// Imported by iq_free_picker and iq_allocator.
package iq_pkg;

  localparam int CIQ_DEPTH  = 16;
  localparam int IQ_ADDR_W  = 4;
  localparam int DECODE_NUM = 4;
  localparam int ISSUE_NUM  = 4;
  localparam int DEC_IDX_W  = $clog2(DECODE_NUM);

  localparam logic [IQ_ADDR_W:0] DEPTH_CNT = (IQ_ADDR_W+1)'(CIQ_DEPTH);

  typedef logic [IQ_ADDR_W-1:0] iq_addr_t;
  typedef logic [CIQ_DEPTH-1:0] iq_mask_t;

  function automatic logic [IQ_ADDR_W:0] popcount(input iq_mask_t m);
    logic [IQ_ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      c = c + {{IQ_ADDR_W{1'b0}}, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/iq_free_picker.sv
// Combinational finder of the DECODE_NUM lowest-index free CIQ entries.
// Output k holds the k-th lowest free index; unused outputs read as 0 / invalid.
module iq_free_picker
  import iq_pkg::*;
(
  input  iq_mask_t                              i_freeMask,
  output logic [DECODE_NUM-1:0][IQ_ADDR_W-1:0]  o_pickAddr,
  output logic [DECODE_NUM-1:0]                 o_pickValid
);

  logic [DEC_IDX_W:0] w_found;

  always_comb begin
    o_pickAddr  = '0;
    o_pickValid = '0;
    w_found     = '0;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      if (i_freeMask[i] && (w_found < (DEC_IDX_W+1)'(DECODE_NUM))) begin
        o_pickAddr[w_found[DEC_IDX_W-1:0]]  = IQ_ADDR_W'(i);
        o_pickValid[w_found[DEC_IDX_W-1:0]] = 1'b1;
        w_found = w_found + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iq_allocator.sv
// CIQ entry allocator: free-mask tracking, all-or-nothing group allocation, release, flush.
// Optional IQ_ALLOC_STATS_EN adds saturating stall/allocation counters (tied to 0 otherwise).
module iq_allocator
  import iq_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DECODE_NUM-1:0]                 alloc_req,
  output logic [DECODE_NUM-1:0][IQ_ADDR_W-1:0]  free_addr,
  output logic [DECODE_NUM-1:0]                 free_valid,
  output logic                                  alloc_stall,
  input  logic [ISSUE_NUM-1:0][IQ_ADDR_W-1:0]   arbit_addr,
  input  logic [ISSUE_NUM-1:0]                  arbit_grant,
  input  logic                                  flush,
  output logic [IQ_ADDR_W:0]                    iq_count,
  output logic                                  iq_full,
  output logic                                  iq_empty,
  output logic [31:0]                           stall_cycles,
  output logic [31:0]                           alloc_total
);

  iq_mask_t                              r_freeMask;
  iq_mask_t                              w_freeNext;
  iq_mask_t                              w_allocMask;
  iq_mask_t                              w_relMask;
  logic [IQ_ADDR_W:0]                    r_count;
  logic [DECODE_NUM-1:0][IQ_ADDR_W-1:0]  w_pickAddr;
  logic [DECODE_NUM-1:0][IQ_ADDR_W-1:0]  w_slotAddr;
  logic [DECODE_NUM-1:0]                 w_pickValid;
  logic [DEC_IDX_W:0]                    w_nReq;
  logic                                  w_covered;
  logic                                  w_accept;

  iq_free_picker u_picker (
    .i_freeMask  (r_freeMask),
    .o_pickAddr  (w_pickAddr),
    .o_pickValid (w_pickValid)
  );

  // The k-th requesting slot takes pick k; the group fits only if every such pick exists.
  always_comb begin
    w_slotAddr = '0;
    w_covered  = 1'b1;
    w_nReq     = '0;
    for (int s = 0; s < DECODE_NUM; s++) begin
      if (alloc_req[s]) begin
        w_slotAddr[s] = w_pickAddr[w_nReq[DEC_IDX_W-1:0]];
        w_covered     = w_covered & w_pickValid[w_nReq[DEC_IDX_W-1:0]];
        w_nReq        = w_nReq + 1'b1;
      end
    end
  end

  assign w_accept    = rst_n && !flush && w_covered;
  assign alloc_stall = !rst_n || ((w_nReq != '0) && !w_accept);
  assign free_valid  = w_accept ? alloc_req : '0;
  assign free_addr   = w_slotAddr;

  always_comb begin
    w_allocMask = '0;
    w_relMask   = '0;
    for (int s = 0; s < DECODE_NUM; s++) begin
      if (free_valid[s]) w_allocMask[w_slotAddr[s]] = 1'b1;
    end
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (arbit_grant[j]) w_relMask[arbit_addr[j]] = 1'b1;
    end
    w_freeNext = flush ? '1 : ((r_freeMask & ~w_allocMask) | w_relMask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freeMask <= '1;
      r_count    <= '0;
    end else begin
      r_freeMask <= w_freeNext;
      r_count    <= DEPTH_CNT - popcount(w_freeNext);
    end
  end

  assign iq_count = r_count;
  assign iq_full  = (r_count == DEPTH_CNT);
  assign iq_empty = (r_count == '0);

  // Releasing an entry that is already free means the arbiter and allocator disagree.
  assert property (@(posedge clk) disable iff (!rst_n)
    !flush |-> ((w_relMask & r_freeMask) == '0));

`ifdef IQ_ALLOC_STATS_EN
  logic [31:0] r_stallCycles;
  logic [31:0] r_allocTotal;
  logic [32:0] w_totalSum;

  assign w_totalSum = {1'b0, r_allocTotal} + 33'(popcount(iq_mask_t'(free_valid)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= '0;
      r_allocTotal  <= '0;
    end else begin
      if (alloc_stall && (w_nReq != '0) && (r_stallCycles != '1)) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
      r_allocTotal <= w_totalSum[32] ? '1 : w_totalSum[31:0];
    end
  end

  assign stall_cycles = r_stallCycles;
  assign alloc_total  = r_allocTotal;
`else
  assign stall_cycles = '0;
  assign alloc_total  = '0;
`endif

endmodule

// File: tb/tb_iq_allocator.sv
// Directed scoreboard bench for iq_allocator: allocation order, stall, release, flush, reset.
module tb_iq_allocator;
  import iq_pkg::*;

  logic                                  clk;
  logic                                  rst_n;
  logic [DECODE_NUM-1:0]                 alloc_req;
  logic [DECODE_NUM-1:0][IQ_ADDR_W-1:0]  free_addr;
  logic [DECODE_NUM-1:0]                 free_valid;
  logic                                  alloc_stall;
  logic [ISSUE_NUM-1:0][IQ_ADDR_W-1:0]   arbit_addr;
  logic [ISSUE_NUM-1:0]                  arbit_grant;
  logic                                  flush;
  logic [IQ_ADDR_W:0]                    iq_count;
  logic                                  iq_full;
  logic                                  iq_empty;
  logic [31:0]                           stall_cycles;
  logic [31:0]                           alloc_total;

  typedef struct {
    string       tag;
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [15:0] addrMask;
    logic        stall;
  } exp_t;

  exp_t        sbQ[$];
  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] expStallCnt = 0;
  logic [31:0] expTotal    = 0;

  iq_allocator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .free_addr    (free_addr),
    .free_valid   (free_valid),
    .alloc_stall  (alloc_stall),
    .arbit_addr   (arbit_addr),
    .arbit_grant  (arbit_grant),
    .flush        (flush),
    .iq_count     (iq_count),
    .iq_full      (iq_full),
    .iq_empty     (iq_empty),
    .stall_cycles (stall_cycles),
    .alloc_total  (alloc_total)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      compareVal("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sbQ.pop_front();
      compareVal({e.tag, ".valid"}, 32'(free_valid), 32'(e.valid));
      compareVal({e.tag, ".addr"}, 32'(free_addr & e.addrMask), 32'(e.addr & e.addrMask));
      compareVal({e.tag, ".stall"}, 32'(alloc_stall), 32'(e.stall));
    end
  endtask

  task automatic checkCount(input string tag, input int expCount);
    compareVal({tag, ".count"}, 32'(iq_count), 32'(expCount));
    compareVal({tag, ".full"}, 32'(iq_full), 32'(expCount == CIQ_DEPTH));
    compareVal({tag, ".empty"}, 32'(iq_empty), 32'(expCount == 0));
  endtask

  // Drive one cycle, queue what the outputs must look like, check mid-cycle, commit on the edge.
  task automatic applyStimulus(input string tag, input logic [3:0] req, input logic [3:0] grant,
                               input logic [15:0] gaddr, input logic fl,
                               input logic [3:0] expValid, input logic [15:0] expAddr,
                               input logic expStall);
    exp_t e;
    e.tag      = tag;
    e.valid    = expValid;
    e.addr     = expAddr;
    e.stall    = expStall;
    e.addrMask = '0;
    for (int s = 0; s < 4; s++) begin
      if (!req[s] || expValid[s]) e.addrMask[s*4 +: 4] = 4'hF;
    end
    alloc_req   = req;
    arbit_grant = grant;
    arbit_addr  = gaddr;
    flush       = fl;
    sbQ.push_back(e);
    @(negedge clk);
    checkOutput();
    if (rst_n) begin
      if (expStall && (req != 4'd0)) expStallCnt = expStallCnt + 1;
      expTotal = expTotal + 32'($countones(expValid));
    end
    @(posedge clk);
    #1;
    alloc_req   = '0;
    arbit_grant = '0;
    arbit_addr  = '0;
    flush       = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    alloc_req   = '0;
    arbit_grant = '0;
    arbit_addr  = '0;
    flush       = 1'b0;

    applyStimulus("reset", 4'b0000, 4'b0000, 16'h0000, 1'b0, 4'b0000, 16'h0000, 1'b1);
    checkCount("reset", 0);
    rst_n = 1'b1;

    applyStimulus("alloc0", 4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b1111, 16'h3210, 1'b0);
    checkCount("alloc0", 4);
    applyStimulus("alloc1", 4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b1111, 16'h7654, 1'b0);
    checkCount("alloc1", 8);
    applyStimulus("alloc2", 4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b1111, 16'hBA98, 1'b0);
    checkCount("alloc2", 12);
    applyStimulus("alloc3", 4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b1111, 16'hFEDC, 1'b0);
    checkCount("alloc3", 16);
    applyStimulus("full_req", 4'b0001, 4'b0000, 16'h0000, 1'b0, 4'b0000, 16'h0000, 1'b1);
    checkCount("full_req", 16);

    applyStimulus("rel_5_9", 4'b0000, 4'b0011, 16'h0095, 1'b0, 4'b0000, 16'h0000, 1'b0);
    checkCount("rel_5_9", 14);
    applyStimulus("req3_of2", 4'b0111, 4'b0000, 16'h0000, 1'b0, 4'b0000, 16'h0000, 1'b1);
    checkCount("req3_of2", 14);
    applyStimulus("req_0110", 4'b0110, 4'b0000, 16'h0000, 1'b0, 4'b0110, 16'h0950, 1'b0);
    checkCount("req_0110", 16);

    applyStimulus("rel_7_11", 4'b0000, 4'b0011, 16'h00B7, 1'b0, 4'b0000, 16'h0000, 1'b0);
    checkCount("rel_7_11", 14);
    applyStimulus("no_bypass", 4'b0111, 4'b0001, 16'h0002, 1'b0, 4'b0000, 16'h0000, 1'b1);
    checkCount("no_bypass", 13);
    applyStimulus("after_rel", 4'b0111, 4'b0000, 16'h0000, 1'b0, 4'b0111, 16'h0B72, 1'b0);
    checkCount("after_rel", 16);

    applyStimulus("dup_grant", 4'b0000, 4'b1111, 16'h1044, 1'b0, 4'b0000, 16'h0000, 1'b0);
    checkCount("dup_grant", 13);
    applyStimulus("rel_3_5_6", 4'b0000, 4'b0111, 16'h0653, 1'b0, 4'b0000, 16'h0000, 1'b0);
    checkCount("rel_3_5_6", 10);

    applyStimulus("flush", 4'b1111, 4'b0000, 16'h0000, 1'b1, 4'b0000, 16'h0000, 1'b1);
    checkCount("flush", 0);
    applyStimulus("post_flush", 4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b1111, 16'h3210, 1'b0);
    checkCount("post_flush", 4);
    applyStimulus("noncontig", 4'b1010, 4'b0000, 16'h0000, 1'b0, 4'b1010, 16'h5040, 1'b0);
    checkCount("noncontig", 6);
    applyStimulus("alloc_rel", 4'b0001, 4'b0001, 16'h0000, 1'b0, 4'b0001, 16'h0006, 1'b0);
    checkCount("alloc_rel", 6);
    applyStimulus("reuse0", 4'b0011, 4'b0000, 16'h0000, 1'b0, 4'b0011, 16'h0070, 1'b0);
    checkCount("reuse0", 8);
    applyStimulus("rel_1", 4'b0000, 4'b0001, 16'h0001, 1'b0, 4'b0000, 16'h0000, 1'b0);
    checkCount("rel_1", 7);

    rst_n     = 1'b0;
    alloc_req = 4'b1111;
    #1;
    compareVal("midreset.valid", 32'(free_valid), 32'd0);
    compareVal("midreset.stall", 32'(alloc_stall), 32'd1);
    checkCount("midreset", 0);
    alloc_req = '0;
    @(negedge clk);
    rst_n       = 1'b1;
    expStallCnt = 0;
    expTotal    = 0;
    @(posedge clk);
    #1;
    applyStimulus("restart", 4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b1111, 16'h3210, 1'b0);
    checkCount("restart", 4);

`ifdef IQ_ALLOC_STATS_EN
    compareVal("stall_cycles", stall_cycles, expStallCnt);
    compareVal("alloc_total", alloc_total, expTotal);
`else
    compareVal("stall_cycles_tied", stall_cycles, 32'd0);
    compareVal("alloc_total_tied", alloc_total, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
